mul24_seq: RTL and testbench

- Sequential unsigned 24x24 -> 48-bit shift-add multiplier with a start/ready handshake.
- Used as the multiply stage of the Newton-Raphson datapath, where area matters more than latency.
- Operands are captured on start; the full product is presented with a single-cycle ready pulse.

---
 rtl/mul24_pkg.sv | 27 ++
 rtl/mul24_seq_if.sv | 38 +++
 rtl/mul24_step.sv | 36 +++
 rtl/mul24_seq.sv | 116 +++++++++++
 tb/tb_mul24_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mul24_pkg.sv
// ============================================================================
// Module : mul24_pkg
// Brief  : Shared types and sizing constants for the mul24_seq multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mul24_pkg;

  localparam int C_WIDTH          = 24;
  localparam int C_BITS_PER_CYCLE = 1;
  localparam int C_N              = C_WIDTH / C_BITS_PER_CYCLE;
  localparam int C_CNT_W          = $clog2(C_N + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Iteration counter width for an arbitrary WIDTH / BITS_PER_CYCLE pair.
  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul24_seq_if.sv
// ============================================================================
// Module : mul24_seq_if
// Brief  : Start/ready handshake and operand/product bus of mul24_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mul24_seq_if
  import mul24_pkg::*;
#(
  parameter int WIDTH = C_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     input0;
  logic [WIDTH-1:0]     input1;
  logic                 ready;
  logic [2*WIDTH-1:0]   output0;

  modport master (
    output start,
    output input0,
    output input1,
    input  ready,
    input  output0
  );

  modport slave (
    input  start,
    input  input0,
    input  input1,
    output ready,
    output output0
  );

endinterface

`default_nettype wire

// File: rtl/mul24_step.sv
// ============================================================================
// Module : mul24_step
// Brief  : One shift-add iteration: acc + (mcand * digit) << (cnt * BPC).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul24_step
  import mul24_pkg::*;
#(
  parameter int WIDTH          = C_WIDTH,
  parameter int BITS_PER_CYCLE = C_BITS_PER_CYCLE,
  parameter int CNT_W          = cnt_width(WIDTH, BITS_PER_CYCLE)
) (
  input  wire logic [2*WIDTH-1:0]        i_acc,
  input  wire logic [WIDTH-1:0]          i_mcand,
  input  wire logic [BITS_PER_CYCLE-1:0] i_digit,
  input  wire logic [CNT_W-1:0]          i_cnt,
  output logic      [2*WIDTH-1:0]        o_acc_next
);

  // Three extra bits cover the product of the counter with BITS_PER_CYCLE <= 4.
  localparam int C_SH_W = CNT_W + 3;

  logic [2*WIDTH-1:0] w_pp;
  logic [C_SH_W-1:0]  w_sh;

  always_comb begin
    w_pp       = {{WIDTH{1'b0}}, i_mcand} * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, i_digit};
    w_sh       = C_SH_W'(i_cnt) * C_SH_W'(BITS_PER_CYCLE);
    o_acc_next = i_acc + (w_pp << w_sh);
  end

endmodule

`default_nettype wire

// File: rtl/mul24_seq.sv
// ============================================================================
// Module : mul24_seq
// Brief  : Sequential unsigned WIDTH x WIDTH shift-add multiplier, start/ready.
//          Optional MUL24_EARLY_TERM_EN: finish once remaining multiplier is 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul24_seq
  import mul24_pkg::*;
#(
  parameter int WIDTH          = C_WIDTH,
  parameter int BITS_PER_CYCLE = C_BITS_PER_CYCLE
) (
  input wire logic   clk,
  input wire logic   rst_n,
  mul24_seq_if.slave bus
);

  localparam int                 C_NITER = WIDTH / BITS_PER_CYCLE;
  localparam int                 C_CW    = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [C_CW-1:0]    C_LAST  = C_CW'(C_NITER - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] r_out;
  logic [C_CW-1:0]    r_cnt;
  logic               r_ready;
  logic               w_load;
  logic               w_step;
  logic               w_done;

  mul24_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .CNT_W          (C_CW)
  ) u_step (
    .i_acc      (r_acc),
    .i_mcand    (r_mcand),
    .i_digit    (r_mplier[BITS_PER_CYCLE-1:0]),
    .i_cnt      (r_cnt),
    .o_acc_next (w_acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = BUSY;
      BUSY:    if (w_done)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef MUL24_EARLY_TERM_EN
  logic w_rest_zero;
  assign w_rest_zero = ((r_mplier >> BITS_PER_CYCLE) == '0);
`endif

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: w_load = bus.start;
      BUSY: begin
        w_step = 1'b1;
`ifdef MUL24_EARLY_TERM_EN
        w_done = (r_cnt == C_LAST) || w_rest_zero;
`else
        w_done = (r_cnt == C_LAST);
`endif
      end
      default: ;
    endcase
  end

  // The product register only moves on completion, so partial sums never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= w_done;
      if (w_load) begin
        r_mcand  <= bus.input0;
        r_mplier <= bus.input1;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (w_step) begin
        r_acc    <= w_acc_nxt;
        r_mplier <= r_mplier >> BITS_PER_CYCLE;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_done) r_out <= w_acc_nxt;
    end
  end

  assign bus.ready   = r_ready;
  assign bus.output0 = r_out;

endmodule

`default_nettype wire

// File: tb/tb_mul24_seq.sv
// ============================================================================
// Module : tb_mul24_seq
// Brief  : Self-checking bench for mul24_seq against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul24_seq;

  localparam int W = 24;
  localparam int B = 1;
  localparam int N = W / B;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  mul24_seq_if #(.WIDTH(W)) bus_if ();

  mul24_seq #(.WIDTH(W), .BITS_PER_CYCLE(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] ref_prod(input logic [23:0] a, input logic [23:0] b);
    return 48'(a) * 48'(b);
  endfunction

  function automatic int ref_lat(input logic [23:0] b);
`ifdef MUL24_EARLY_TERM_EN
    int hi = 0;
    for (int i = 0; i < W; i++) if (b[i]) hi = i / B;
    return hi + 1;
`else
    return N + 0 * int'(b[0]);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One isolated operation; operands are scrambled right after being sampled.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input string tag);
    int          lat;
    logic        held;
    logic [47:0] prev;
    bus_if.input0 = a;
    bus_if.input1 = b;
    bus_if.start  = 1'b1;
    tick();
    bus_if.start  = 1'b0;
    bus_if.input0 = 24'($urandom);
    bus_if.input1 = 24'($urandom);
    prev = bus_if.output0;
    held = 1'b1;
    lat  = 0;
    for (int k = 1; k <= N + 8; k++) begin
      tick();
      if (bus_if.ready) begin
        lat = k;
        break;
      end
      if (bus_if.output0 !== prev) held = 1'b0;
    end
    chk({tag, " latency"}, 64'(lat), 64'(ref_lat(b)));
    chk({tag, " product"}, 64'(bus_if.output0), 64'(ref_prod(a, b)));
    chk({tag, " output held while busy"}, 64'(held), 64'd1);
    tick();
    chk({tag, " ready one cycle"}, 64'(bus_if.ready), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a, b, a0, b0;
    int          lat, dbl, cnt_rdy, k;

    bus_if.start  = 1'b0;
    bus_if.input0 = '0;
    bus_if.input1 = '0;

    // Reset state
    #12;
    chk("reset ready", 64'(bus_if.ready), 64'd0);
    chk("reset output0", 64'(bus_if.output0), 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed corners
    run_op(24'h000001, 24'h000001, "1x1");
    run_op(24'hFFFFFF, 24'hFFFFFF, "max");
    run_op(24'h800000, 24'h000002, "msb x 2");
    run_op(24'h000000, 24'h123456, "0 x b");
    run_op(24'h123456, 24'h000000, "a x 0");

    // Random operands, including short multipliers
    for (int i = 0; i < 20; i++) begin
      a = 24'($urandom);
      b = (i % 4 == 0) ? 24'($urandom_range(0, 255)) : 24'($urandom);
      run_op(a, b, "random");
    end

    // Operand change and start pulse while busy
    a0 = 24'h123456;
    b0 = 24'h654321;
    bus_if.input0 = a0;
    bus_if.input1 = b0;
    bus_if.start  = 1'b1;
    tick();
    bus_if.start = 1'b0;
    lat = 0;
    k   = 0;
    repeat (5) begin
      tick();
      k++;
    end
    bus_if.input0 = 24'hABCDEF;
    bus_if.input1 = 24'h00FEDC;
    bus_if.start  = 1'b1;
    tick();
    k++;
    bus_if.start = 1'b0;
    while (k < N + 8) begin
      tick();
      k++;
      if (bus_if.ready) begin
        lat = k;
        break;
      end
    end
    chk("busy-start latency", 64'(lat), 64'(ref_lat(b0)));
    chk("busy-start product", 64'(bus_if.output0), 64'(ref_prod(a0, b0)));
    cnt_rdy = 0;
    repeat (40) begin
      tick();
      if (bus_if.ready) cnt_rdy++;
    end
    chk("busy-start no extra ready", 64'(cnt_rdy), 64'd0);

    // Asynchronous reset mid-operation
    bus_if.input0 = 24'h00ABCD;
    bus_if.input1 = 24'hF01234;
    bus_if.start  = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async reset ready", 64'(bus_if.ready), 64'd0);
    chk("async reset output0", 64'(bus_if.output0), 64'd0);
    #2 rst_n = 1'b1;
    cnt_rdy = 0;
    repeat (40) begin
      tick();
      if (bus_if.ready) cnt_rdy++;
    end
    chk("post-reset no ready", 64'(cnt_rdy), 64'd0);
    chk("post-reset output0", 64'(bus_if.output0), 64'd0);

    // Level-held start sweep with operands advancing on each ready
    a = 24'd1;
    b = 24'd1;
    dbl = 0;
    bus_if.input0 = a;
    bus_if.input1 = b;
    bus_if.start  = 1'b1;
    tick();
    for (int p = 0; p < 1000; p++) begin
      lat = 0;
      for (int j = 1; j <= N + 8; j++) begin
        tick();
        if (bus_if.ready) begin
          lat = j;
          break;
        end
      end
      chk("sweep latency", 64'(lat), 64'(ref_lat(b)));
      chk("sweep product", 64'(bus_if.output0), 64'(ref_prod(a, b)));
      a++;
      b++;
      bus_if.input0 = a;
      bus_if.input1 = b;
      if (p == 999) bus_if.start = 1'b0;
      tick();
      if (bus_if.ready) dbl++;
    end
    chk("sweep ready never doubled", 64'(dbl), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
